// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port external memory arbiter.
// State encoding, MemMode access sizes and the port-id type.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef logic portId_t;

    localparam portId_t PORT0 = 1'b0;
    localparam portId_t PORT1 = 1'b1;

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_WORD = 2'b10;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and exmemory.
// slave = arbiter side, master = requester/memory side.
interface mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [1:0]    mode0;
    logic [1:0]    mode1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          mem_we;
    logic [1:0]    mem_mode;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, mode0, mode1,
        input  addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, rdata, busy,
        output mem_we, mem_mode, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, mode0, mode1,
        output addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, rdata, busy,
        input  mem_we, mem_mode, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner select for the memory arbiter.
// MEM_ARB_RR_EN: round-robin with a 1-bit pointer; else port 0 wins.
import mem_arb_pkg::*;

module mem_arb_pick (
`ifdef MEM_ARB_RR_EN
    input  logic    clk,
    input  logic    reset,
    input  logic    grant,
`endif
    input  logic    req0,
    input  logic    req1,
    output portId_t winner
);

`ifdef MEM_ARB_RR_EN
    portId_t ptr;

    // Pointer favours whichever port lost the most recent grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= PORT0;
        end else if (grant) begin
            ptr <= ~winner;
        end
    end

    // Contention resolved by the pointer, otherwise the lone requester
    always_comb begin
        winner = PORT0;
        if (req0 && req1) begin
            winner = ptr;
        end else if (req1) begin
            winner = PORT1;
        end
    end
`else
    // Port 0 always has priority
    always_comb begin
        winner = PORT0;
        if (!req0 && req1) begin
            winner = PORT1;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of exmemory: IDLE -> ACCESS -> RESP.
// Build option MEM_ARB_RR_EN selects round-robin instead of fixed priority.
import mem_arb_pkg::*;

module mem_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    mem_arbiter_if.slave bus
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    portId_t       grantId;
    portId_t       winner;
    logic          isWrite;
    logic          grantNow;
    logic          winWe;
    logic [1:0]    winMode;
    logic [AW-1:0] winAddr;
    logic [DW-1:0] winData;

    assign grantNow = (state == IDLE) && (bus.req0 || bus.req1);
    assign bus.busy = (state != IDLE);

    mem_arb_pick uPick (
`ifdef MEM_ARB_RR_EN
        .clk    (clk),
        .reset  (reset),
        .grant  (grantNow),
`endif
        .req0   (bus.req0),
        .req1   (bus.req1),
        .winner (winner)
    );

    // Route the winning port's request fields
    always_comb begin
        winWe   = bus.we0;
        winMode = bus.mode0;
        winAddr = bus.addr0;
        winData = bus.wdata0;
        if (winner == PORT1) begin
            winWe   = bus.we1;
            winMode = bus.mode1;
            winAddr = bus.addr1;
            winData = bus.wdata1;
        end
    end

    // Transaction FSM; mem_* registers double as the latched request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            grantId       <= PORT0;
            isWrite       <= 1'b0;
            bus.ack0      <= 1'b0;
            bus.ack1      <= 1'b0;
            bus.rdata     <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_mode  <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    bus.ack0 <= 1'b0;
                    bus.ack1 <= 1'b0;
                    if (grantNow) begin
                        state         <= ACCESS;
                        cnt           <= CNT_INIT;
                        grantId       <= winner;
                        isWrite       <= winWe;
                        bus.mem_we    <= winWe;
                        bus.mem_mode  <= winMode;
                        bus.mem_addr  <= winAddr;
                        bus.mem_wdata <= winData;
                    end
                end
                ACCESS: begin
                    bus.mem_we <= 1'b0;
                    if (cnt == '0) begin
                        state         <= RESP;
                        bus.rdata     <= isWrite ? '0 : bus.mem_rdata;
                        bus.ack0      <= (grantId == PORT0);
                        bus.ack1      <= (grantId == PORT1);
                        bus.mem_mode  <= '0;
                        bus.mem_addr  <= '0;
                        bus.mem_wdata <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    bus.ack0 <= 1'b0;
                    bus.ack1 <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: MEM_LAT=1 and MEM_LAT=3 instances.
// Arbitration expectations follow MEM_ARB_RR_EN.
import mem_arb_pkg::*;

module tb_mem_arbiter;

    logic clk;
    logic reset;
    logic preWe;
    logic [7:0] preIdx;
    logic [31:0] preDat;
    logic [31:0] memA [0:255];
    logic [31:0] memB [0:255];
    int total;
    int passed;

`ifdef MEM_ARB_RR_EN
    localparam int NEXP = 4;
    int expOrd [4] = '{0, 1, 0, 1};
`else
    localparam int NEXP = 5;
    int expOrd [5] = '{0, 0, 0, 0, 1};
`endif

    mem_arbiter_if #(.AW(16), .DW(32)) a ();
    mem_arbiter_if #(.AW(16), .DW(32)) b ();

    mem_arbiter #(.AW(16), .DW(32), .MEM_LAT(1)) dutA (
        .clk   (clk),
        .reset (reset),
        .bus   (a)
    );

    mem_arbiter #(.AW(16), .DW(32), .MEM_LAT(3)) dutB (
        .clk   (clk),
        .reset (reset),
        .bus   (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign a.mem_rdata = memA[a.mem_addr[9:2]];
    assign b.mem_rdata = memB[b.mem_addr[9:2]];

    // Word-addressed memory models with a bench preload port
    always @(posedge clk) begin
        if (preWe) begin
            memA[preIdx] <= preDat;
            memB[preIdx] <= preDat;
        end else begin
            if (a.mem_we) memA[a.mem_addr[9:2]] <= a.mem_wdata;
            if (b.mem_we) memB[b.mem_addr[9:2]] <= b.mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] dat);
        @(negedge clk);
        preWe  = 1'b1;
        preIdx = idx;
        preDat = dat;
        @(negedge clk);
        preWe  = 1'b0;
    endtask

    task automatic xfer1(input bit port, input logic w, input logic [1:0] m,
                         input logic [15:0] ad, input logic [31:0] wd,
                         input logic [31:0] expRd, input string tag,
                         input bit dropEarly);
        if (!port) begin
            a.we0 = w; a.mode0 = m; a.addr0 = ad; a.wdata0 = wd; a.req0 = 1'b1;
        end else begin
            a.we1 = w; a.mode1 = m; a.addr1 = ad; a.wdata1 = wd; a.req1 = 1'b1;
        end
        @(negedge clk);
        check({tag, "_addr"}, 32'(a.mem_addr), 32'(ad));
        check({tag, "_we"}, 32'(a.mem_we), 32'(w));
        check({tag, "_mode"}, 32'(a.mem_mode), 32'(m));
        check({tag, "_wdata"}, a.mem_wdata, w ? wd : 32'h0);
        check({tag, "_busy"}, 32'(a.busy), 32'd1);
        check({tag, "_noack"}, 32'(a.ack0 | a.ack1), 32'd0);
        if (!port) begin
            a.addr0 = ~ad; a.wdata0 = ~wd; a.we0 = ~w;
            if (dropEarly) a.req0 = 1'b0;
        end else begin
            a.addr1 = ~ad; a.wdata1 = ~wd; a.we1 = ~w;
            if (dropEarly) a.req1 = 1'b0;
        end
        @(negedge clk);
        check({tag, "_ack0"}, 32'(a.ack0), 32'(!port));
        check({tag, "_ack1"}, 32'(a.ack1), 32'(port));
        check({tag, "_rdata"}, a.rdata, expRd);
        check({tag, "_weoff"}, 32'(a.mem_we), 32'd0);
        check({tag, "_addroff"}, 32'(a.mem_addr), 32'd0);
        a.req0 = 1'b0;
        a.req1 = 1'b0;
        @(negedge clk);
        check({tag, "_idle"}, 32'(a.busy), 32'd0);
        check({tag, "_ackoff"}, 32'(a.ack0 | a.ack1), 32'd0);
    endtask

    initial begin
        int order[$];
        int ackCyc[$];
        int addrRuns[$];
        int addrRun;
        bit ackSeen;
        total = 0;
        passed = 0;
        reset = 1'b0;
        preWe = 1'b0;
        preIdx = '0;
        preDat = '0;
        a.req0 = 0; a.req1 = 0; a.we0 = 0; a.we1 = 0;
        a.mode0 = 0; a.mode1 = 0; a.addr0 = 0; a.addr1 = 0;
        a.wdata0 = 0; a.wdata1 = 0;
        b.req0 = 0; b.req1 = 0; b.we0 = 0; b.we1 = 0;
        b.mode0 = 0; b.mode1 = 0; b.addr0 = 0; b.addr1 = 0;
        b.wdata0 = 0; b.wdata1 = 0;
        #2 reset = 1'b1;

        preload(8'h04, 32'h12345678);
        preload(8'h0C, 32'hA5A5A5A5);
        preload(8'h10, 32'h11111111);
        #1;
        check("rst_busy", 32'(a.busy), 32'd0);
        check("rst_ack", 32'(a.ack0 | a.ack1), 32'd0);
        check("rst_we", 32'(a.mem_we), 32'd0);
        check("rst_addr", 32'(a.mem_addr), 32'd0);
        check("rst_rdata", a.rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        xfer1(1'b0, 1'b0, MODE_WORD, 16'h0010, 32'h0, 32'h12345678, "rd0", 1'b0);
        xfer1(1'b1, 1'b1, MODE_WORD, 16'h0020, 32'hDEADBEEF, 32'h0, "wr1", 1'b0);
        check("wr1_mem", memA[8], 32'hDEADBEEF);
        xfer1(1'b0, 1'b0, MODE_WORD, 16'h0020, 32'h0, 32'hDEADBEEF, "rd0b", 1'b1);

        a.we1 = 1'b1; a.mode1 = MODE_WORD; a.addr1 = 16'h0040;
        a.wdata1 = 32'hCAFEF00D; a.req1 = 1'b1;
        @(negedge clk);
        check("mid_we", 32'(a.mem_we), 32'd1);
        reset = 1'b1;
        a.req1 = 1'b0;
        #1;
        check("mid_we0", 32'(a.mem_we), 32'd0);
        check("mid_addr0", 32'(a.mem_addr), 32'd0);
        check("mid_wdata0", a.mem_wdata, 32'd0);
        check("mid_mode0", 32'(a.mem_mode), 32'd0);
        check("mid_busy0", 32'(a.busy), 32'd0);
        check("mid_rdata0", a.rdata, 32'd0);
        ackSeen = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("mid_mem", memA[16], 32'h11111111);
        repeat (3) begin
            @(negedge clk);
            ackSeen |= a.ack0 | a.ack1;
        end
        check("mid_noack", 32'(ackSeen), 32'd0);
        check("mid_idle", 32'(a.busy), 32'd0);
        xfer1(1'b1, 1'b1, MODE_HALF, 16'h0040, 32'hCAFEF00D, 32'h0, "wr1b", 1'b0);
        check("wr1b_mem", memA[16], 32'hCAFEF00D);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        a.we0 = 0; a.mode0 = MODE_WORD; a.addr0 = 16'h0010;
        a.we1 = 0; a.mode1 = MODE_WORD; a.addr1 = 16'h0030;
        a.req0 = 1'b1;
        a.req1 = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (a.ack0 || a.ack1) begin
                check("arb_excl", 32'(a.ack0 & a.ack1), 32'd0);
                order.push_back(a.ack1 ? 1 : 0);
                check("arb_rdata", a.rdata,
                      a.ack1 ? 32'hA5A5A5A5 : 32'h12345678);
                if (order.size() == NEXP) begin
                    a.req0 = 1'b0;
                    a.req1 = 1'b0;
                    break;
                end
                if (order.size() == 4) a.req0 = 1'b0;
            end
        end
        a.req0 = 1'b0;
        a.req1 = 1'b0;
        check("arb_count", 32'(order.size()), 32'(NEXP));
        for (int i = 0; i < NEXP; i++) begin
            if (i < order.size())
                check($sformatf("arb_ord%0d", i), 32'(order[i]), 32'(expOrd[i]));
        end

        @(negedge clk);
        b.we0 = 1'b0; b.mode0 = MODE_WORD; b.addr0 = 16'h0010;
        b.req0 = 1'b1;
        addrRun = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (b.mem_addr == 16'h0010) addrRun++;
            if (b.ack0) begin
                ackCyc.push_back(cyc);
                addrRuns.push_back(addrRun);
                addrRun = 0;
                check("lat3_rdata", b.rdata, 32'h12345678);
                if (ackCyc.size() == 3) begin
                    b.req0 = 1'b0;
                    break;
                end
            end
        end
        b.req0 = 1'b0;
        check("lat3_count", 32'(ackCyc.size()), 32'd3);
        if (ackCyc.size() == 3) begin
            check("lat3_first", 32'(ackCyc[0]), 32'd4);
            check("lat3_gap1", 32'(ackCyc[1] - ackCyc[0]), 32'd5);
            check("lat3_gap2", 32'(ackCyc[2] - ackCyc[1]), 32'd5);
            for (int i = 0; i < 3; i++)
                check($sformatf("lat3_addr%0d", i), 32'(addrRuns[i]), 32'd3);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
